rhs2116_frame_buffer: RTL and testbench
=======================================

Name: rhs2116_frame_buffer

Overview:
- Consumer stage directly downstream of spi_master_rhs2116, in the clk_spi domain.
- Drops the pipeline-latency frames the RHS2116 returns after the master is enabled.
- Tags each valid 32-bit result with a channel index and a start-of-scan marker.
- Buffers tagged words in a synchronous FIFO and hands them to the coax link serializer over a valid/ready interface, reporting overflow when the serializer stalls.

Parameters:
- DISCARD_FRAMES, 2: frames dropped after each enable rising edge (RHS2116 command pipeline latency).
- NUM_CH, 16: channels per scan; the channel index wraps at NUM_CH-1.
- CH_W, 4: channel index width, at least clog2(NUM_CH).
- FIFO_DEPTH, 16: FIFO entries; must be a power of two and at least 2.

Ports:
- clk_spi  in  1  64 MHz SPI-domain clock.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  same enable signal that drives spi_master_rhs2116.
- in_data  in  32  spi_master data_out.
- in_valid  in  1  spi_master data_valid; single-cycle pulse.
- clr_ovf  in  1  one-cycle pulse; clears overflow and drop_cnt.
- out_data  out  32  sample word.
- out_chan  out  CH_W  channel index of out_data.
- out_sof  out  1  high when out_chan == 0 (first word of a scan).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts; a pop occurs when out_valid && out_ready.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- drop_cnt  out  8  count of dropped words; saturates at 255.
- fill_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clk_spi edge):
  - state = IDLE; FIFO emptied; all pointers, discard counter and channel counter = 0.
  - out_valid = 0, overflow = 0, drop_cnt = 0, fill_level = 0.
  - out_data, out_chan and out_sof = 0.
  - Reset mid-scan discards all buffered words. No partial scan survives.
- State machine (state held in a register; enable is sampled each cycle):
  - IDLE: if enable = 1, go to DISCARD with disc_cnt = 0. in_valid is ignored in IDLE.
  - DISCARD: each in_valid increments disc_cnt and the word is dropped. It does not count as overflow.
    - On the in_valid that makes disc_cnt reach DISCARD_FRAMES, go to RUN with chan_cnt = 0.
    - DISCARD_FRAMES = 0 means DISCARD passes straight to RUN on the next cycle.
  - RUN: each in_valid pushes {in_data, chan_cnt, chan_cnt == 0}. chan_cnt increments and wraps NUM_CH-1 -> 0.
  - Any state with enable = 0: go to IDLE next cycle.
    - An in_valid in that same cycle is still handled by the current state.
    - The FIFO is not flushed; buffered words keep draining through out_ready.
    - Re-enabling restarts the discard sequence and resets chan_cnt to 0.
- FIFO (sub-module):
  - A push is accepted when not full, or when full and a pop occurs in the same cycle.
  - A rejected push sets overflow and increments drop_cnt (saturating at 255). chan_cnt still advances, so tags stay aligned to the SPI sequence.
  - Latency: push in cycle N makes out_valid = 1 from cycle N+1. The output fields reflect the head entry (registered read, no bubble).
  - A pop when empty has no effect.
  - A simultaneous push and pop leaves fill_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are resolved with an extra pointer MSB.
- Sticky status:
  - clr_ovf clears overflow and drop_cnt next cycle.
  - A drop in the same cycle as clr_ovf wins: overflow = 1, drop_cnt = 1.
- Output data must be stable while out_valid && !out_ready (AXI-style hold).

Decomposition:
- Package rhs2116_pkg:
  - state enum {IDLE, DISCARD, RUN}.
  - Constants RHS_WORD_W = 32, DEF_DISCARD = 2, DEF_NUM_CH = 16.
  - Packed FIFO-entry typedef {data[31:0], chan, sof}.
- Sub-module sync_fifo: parameterised width/depth, push/pop/full/empty/level. Reusable elsewhere in the link path.
- Top module: FSM, counters and status logic.

Test Plan:
- Reset with enable = 0 and in_valid pulses on 0x11111111 -> out_valid stays 0, fill_level = 0.
- enable = 1, out_ready = 1, words 0xA5A50000..0xA5A50004 -> first two dropped; 0xA5A50002 emerges with out_chan = 0 and out_sof = 1; the next words carry chan 1 and 2.
- 40 consecutive words in RUN with out_ready = 1 -> out_chan sequence 0..15, 0..15, 0..7; out_sof high exactly 3 times.
- out_ready = 0, 20 words pushed in RUN -> fill_level = 16, overflow = 1, drop_cnt = 4. Releasing out_ready drains the 16 oldest in order. clr_ovf then returns drop_cnt to 0.
- Full FIFO with a push and pop in the same cycle -> no drop, fill_level stays 16, drop_cnt unchanged.
- rst_n low for one cycle mid-scan with 5 words buffered -> fill_level = 0, state IDLE. After reset, enable = 1 gives two discards, then chan 0 again.

Source files
------------

// File: rtl/rhs2116_pkg.sv
// rhs2116_pkg
//   Shared types and constants for the RHS2116 consumer path.
//   - state_t      : frame-buffer controller state (IDLE, DISCARD, RUN)
//   - RHS_WORD_W   : width of one RHS2116 result word
//   - DEF_*        : default discard count, channel count and channel tag width
//   - fifo_entry_t : tagged FIFO entry {data, chan, sof} for the default config
package rhs2116_pkg;

  localparam int RHS_WORD_W  = 32;
  localparam int DEF_DISCARD = 2;
  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CH_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    RUN     = 2'd2
  } state_t;

  typedef struct packed {
    logic [RHS_WORD_W-1:0] data;
    logic [DEF_CH_W-1:0]   chan;
    logic                  sof;
  } fifo_entry_t;

endpackage

// File: rtl/rhs2116_frame_buffer_sync_fifo.sv
// sync_fifo
//   Generic single-clock FIFO, first-word-fall-through.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset (empties the FIFO)
//     push        : write request; accepted when not full, or when full and a
//                   pop happens in the same cycle
//     push_data   : word to write
//     pop         : read request; ignored when empty
//     pop_data    : head entry (zero while empty)
//     full, empty : occupancy flags
//     level       : number of stored entries (0..DEPTH)
//   DEPTH must be a power of two and at least 2.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra MSB so full and empty are distinguishable
  // when the low bits are equal.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a push lands.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head is presented straight from storage so a new word is visible the
  // cycle after its push and the next word follows a pop with no bubble.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rhs2116_frame_buffer.sv
// rhs2116_frame_buffer
//   Sits behind spi_master_rhs2116 in the clk_spi domain. Drops the
//   pipeline-latency frames returned after each enable, tags the remaining
//   results with a channel index and start-of-scan flag, and buffers them
//   for the coax link serializer.
//   Ports:
//     clk_spi, rst_n  : clock, synchronous active-low reset
//     enable          : master enable (rising edge restarts the discard phase)
//     in_data/in_valid: result word and its single-cycle strobe
//     clr_ovf         : pulse clearing overflow and drop_cnt
//     out_data/out_chan/out_sof/out_valid/out_ready : tagged output stream
//     overflow        : sticky, a word was lost to a full FIFO
//     drop_cnt        : lost-word count, saturating at 255
//     fill_level      : FIFO occupancy
//     dbg_state       : current controller state (state_t encoding)
//   Output handshake: a word transfers on a clk_spi edge where out_valid and
//   out_ready are both high; while out_valid is high and out_ready low the
//   out_* fields hold their value and out_valid does not drop.
module rhs2116_frame_buffer
  import rhs2116_pkg::*;
#(
  parameter int DISCARD_FRAMES = DEF_DISCARD,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CH_W           = DEF_CH_W,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk_spi,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   in_data,
  input  logic                          in_valid,
  input  logic                          clr_ovf,
  output logic [31:0]                   out_data,
  output logic [CH_W-1:0]               out_chan,
  output logic                          out_sof,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [1:0]                    dbg_state
);

  localparam int EW     = RHS_WORD_W + CH_W + 1;
  localparam int DISC_W = (DISCARD_FRAMES < 2) ? 1 : $clog2(DISCARD_FRAMES);
  localparam logic [DISC_W-1:0] DISC_LAST =
    DISC_W'((DISCARD_FRAMES > 0) ? DISCARD_FRAMES - 1 : 0);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     pop_data;

  always_ff @(posedge clk_spi) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disc_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    chan_d  = chan_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = DISCARD;
          disc_d  = '0;
        end
      end
      DISCARD: begin
        if (DISCARD_FRAMES == 0) begin
          state_d = RUN;
          chan_d  = '0;
        end else if (in_valid) begin
          // disc_q counts frames already dropped; this one is the last.
          if (disc_q == DISC_LAST) begin
            state_d = RUN;
            chan_d  = '0;
          end else begin
            disc_d = disc_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          push   = 1'b1;
          // Advances even when the push is dropped, keeping tags aligned
          // with the SPI channel sequence.
          chan_d = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The current state still handles an in_valid in the disabling cycle.
    if (!enable) state_d = IDLE;
  end

  assign push_data = {in_data, chan_q, (chan_q == '0)};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_spi),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fill_level)
  );

  // Full implies non-empty, so a same-cycle out_ready always makes room.
  assign drop = push && fifo_full && !out_ready;

  always_ff @(posedge clk_spi) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      // A drop coinciding with clr_ovf restarts the count at one.
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = pop_data[EW-1 -: RHS_WORD_W];
  assign out_chan  = pop_data[CH_W:1];
  assign out_sof   = pop_data[0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rhs2116_frame_buffer.sv
// tb_rhs2116_frame_buffer
//   Directed bench for rhs2116_frame_buffer. Expected tagged words are queued
//   as stimulus is issued; a monitor thread pops and compares each accepted
//   output word. Status outputs are checked at fixed points.
module tb_rhs2116_frame_buffer;
  import rhs2116_pkg::*;

  localparam int CH_W = 4;
  localparam int EW   = 32 + CH_W + 1;

  logic            clk_spi;
  logic            rst_n;
  logic            enable;
  logic [31:0]     in_data;
  logic            in_valid;
  logic            clr_ovf;
  logic [31:0]     out_data;
  logic [CH_W-1:0] out_chan;
  logic            out_sof;
  logic            out_valid;
  logic            out_ready;
  logic            overflow;
  logic [7:0]      drop_cnt;
  logic [4:0]      fill_level;
  logic [1:0]      dbg_state;

  rhs2116_frame_buffer dut (
    .clk_spi    (clk_spi),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clr_ovf    (clr_ovf),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_sof    (out_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fill_level (fill_level),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_spi = 1'b0;
  always #5 clk_spi = ~clk_spi;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int checks   = 0;
  int errors   = 0;
  int sof_seen = 0;

  function automatic logic [EW-1:0] ent(input logic [31:0] d, input int ch);
    fifo_entry_t e;
    e.data = d;
    e.chan = ch[3:0];
    e.sof  = (ch == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk_spi);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [31:0] d, input int ch);
    exp_q.push_back(ent(d, ch));
    send(d);
  endtask

  // Drop enable for a cycle, re-enable, and feed the two latency frames.
  task automatic restart();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    cycle();
    send(32'hDEAD0000);
    send(32'hDEAD0001);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cycle();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- main sequence + monitor ----------------
  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk_spi);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected none", {out_data, out_chan, out_sof});
          end else begin
            mon_e = exp_q.pop_front();
            check("out_word", {out_data, out_chan, out_sof}, mon_e);
          end
          if (out_sof) sof_seen++;
        end
      end
    join_none

    // Reset state
    repeat (3) cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_fill", fill_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    cycle();

    // in_valid ignored while disabled
    repeat (3) send(32'h11111111);
    cycle();
    check("idle_out_valid", out_valid, 0);
    check("idle_fill", fill_level, 0);
    check("idle_state", dbg_state, IDLE);

    // First enable: two discards then chan 0,1,2
    out_ready = 1'b1;
    enable    = 1'b1;
    cycle();
    check("discard_state", dbg_state, DISCARD);
    send(32'hA5A50000);
    send(32'hA5A50001);
    check("run_state", dbg_state, RUN);
    check("discard_no_push", fill_level, 0);
    send_exp(32'hA5A50002, 0);
    send_exp(32'hA5A50003, 1);
    send_exp(32'hA5A50004, 2);
    wait_drain();

    // 40 words: chan 0..15, 0..15, 0..7 with three sof
    restart();
    sof_seen = 0;
    for (int i = 0; i < 40; i++) send_exp(32'hB0000000 + i, i % 16);
    wait_drain();
    check("sof_count", sof_seen, 3);

    // Stall: 20 words into a 16-deep FIFO
    out_ready = 1'b0;
    restart();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) send_exp(32'hC0000000 + i, i);
      else        send(32'hC0000000 + i);
    end
    check("stall_fill", fill_level, 16);
    check("stall_overflow", overflow, 1);
    check("stall_drop_cnt", drop_cnt, 4);
    check("stall_valid", out_valid, 1);
    check("hold_head_a", {out_data, out_chan, out_sof}, exp_q[0]);
    repeat (3) cycle();
    check("hold_head_b", {out_data, out_chan, out_sof}, exp_q[0]);

    // Full FIFO, push and pop in the same cycle: no drop
    exp_q.push_back(ent(32'hC0000100, 4));
    in_data   = 32'hC0000100;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pushpop_fill", fill_level, 16);
    check("pushpop_drop_cnt", drop_cnt, 4);

    // Drain in order, then clear status
    out_ready = 1'b1;
    wait_drain();
    check("drained_fill", fill_level, 0);
    check("drained_valid", out_valid, 0);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_drop_cnt", drop_cnt, 0);

    // Drop coinciding with clr_ovf wins
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_exp(32'hD0000000 + i, (5 + i) % 16);
    check("refill_fill", fill_level, 16);
    check("refill_drop_cnt", drop_cnt, 0);
    clr_ovf = 1'b1;
    send(32'hD00000FF);
    clr_ovf = 1'b0;
    check("clrdrop_overflow", overflow, 1);
    check("clrdrop_drop_cnt", drop_cnt, 1);
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-scan with 5 words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_exp(32'hE0000000 + i, (6 + i) % 16);
    check("pre_rst_fill", fill_level, 5);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_fill", fill_level, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_overflow", overflow, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    cycle();
    check("post_rst_discard", dbg_state, DISCARD);
    out_ready = 1'b1;
    send(32'hF000DEAD);
    send(32'hF000BEEF);
    send_exp(32'hF0000000, 0);
    send_exp(32'hF0000001, 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
